// File: rtl/xb_regfile_pkg.sv
// Shared constants for the Xillybus register-file controller.
//   XB_DW / XB_AW   : stream word width and register address width
//   CTRL_* / STAT_* : named register indices used by software and the datapath
package xb_regfile_pkg;

    localparam int XB_DW = 16;
    localparam int XB_AW = 5;

    // Control (read/write) register indices
    localparam int CTRL_RUN       = 0;
    localparam int CTRL_CHMASK    = 1;
    localparam int CTRL_THR_SCALE = 2;

    // Status (read-only) register indices
    localparam int STAT_FIFO_LVL  = 16;
    localparam int STAT_OVF       = 17;

    typedef logic [XB_DW-1:0] xb_word_t;

endpackage

// File: rtl/xb_seek_ptr.sv
// Loadable auto-increment pointer.
//   clk, srst : clock and synchronous active-high reset (pointer -> 0)
//   load      : load_val replaces the current pointer
//   inc       : advance by one; combined with load, the result is load_val+1
//   ptr       : current pointer value
// WRAP=1 wraps from LIMIT-1 to 0; WRAP=0 parks at LIMIT (end-of-file marker).
module xb_seek_ptr #(
    parameter int W     = 5,
    parameter int LIMIT = 32,
    parameter int WRAP  = 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_reg;
    logic [W-1:0] ptr_next;
    logic [W-1:0] base;

    always_comb begin
        base     = load ? load_val : ptr_reg;
        ptr_next = base;
        if (inc) begin
            // >= also catches a parked pointer so it can never run past LIMIT
            if (int'(base) >= LIMIT - 1) begin
                ptr_next = (WRAP != 0) ? '0 : W'(LIMIT);
            end else begin
                ptr_next = base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/xb_ctrl_regfile.sv
// Register-file controller behind the control_regs_16 (write) and
// status_regs_16 (read) addressed Xillybus streams.
//   bus_clk, bus_rst               : clock, synchronous active-high reset
//   user_w_control_regs_16_*       : write stream (open/wren/data/full)
//   user_control_regs_16_addr*     : write seek
//   user_r_status_regs_16_*        : read stream (open/rden/data/empty/eof)
//   user_status_regs_16_addr*      : read seek
//   status_in                      : live status words, word k = index RO_BASE+k
//   ctrl_out                       : control register contents, word k = index k
//   ctrl_wr_strobe                 : one-cycle pulse per written control register
//   ro_violation                   : sticky, set by a write to a read-only index
module xb_ctrl_regfile
    import xb_regfile_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int RO_BASE = 16,
    parameter int WRAP    = 1
) (
    input  logic                            bus_clk,
    input  logic                            bus_rst,
    input  logic                            user_w_control_regs_16_open,
    input  logic                            user_w_control_regs_16_wren,
    input  logic [XB_DW-1:0]                user_w_control_regs_16_data,
    output logic                            user_w_control_regs_16_full,
    input  logic [$clog2(NREGS)-1:0]        user_control_regs_16_addr,
    input  logic                            user_control_regs_16_addr_update,
    input  logic                            user_r_status_regs_16_open,
    input  logic                            user_r_status_regs_16_rden,
    output logic [XB_DW-1:0]                user_r_status_regs_16_data,
    output logic                            user_r_status_regs_16_empty,
    output logic                            user_r_status_regs_16_eof,
    input  logic [$clog2(NREGS)-1:0]        user_status_regs_16_addr,
    input  logic                            user_status_regs_16_addr_update,
    input  logic [XB_DW*(NREGS-RO_BASE)-1:0] status_in,
    output logic [XB_DW*RO_BASE-1:0]        ctrl_out,
    output logic [RO_BASE-1:0]              ctrl_wr_strobe,
    output logic                            ro_violation
);

    localparam int AW    = $clog2(NREGS);
    localparam int NSTAT = NREGS - RO_BASE;

    // ---------------- write side ----------------
    logic [AW-1:0] wp;
    logic [AW-1:0] wr_idx;
    logic          wr_fire;
    logic          wr_ctrl;
    logic          wr_ro;
    logic          full_reg;
    logic          ro_violation_reg;

    assign wr_fire = user_w_control_regs_16_open & user_w_control_regs_16_wren;
    // A seek in the same cycle as a write redirects that write to the new address
    assign wr_idx  = user_control_regs_16_addr_update ? user_control_regs_16_addr : wp;
    assign wr_ctrl = wr_fire &  (int'(wr_idx) < RO_BASE);
    assign wr_ro   = wr_fire & ~(int'(wr_idx) < RO_BASE);

    xb_seek_ptr #(
        .W     (AW),
        .LIMIT (NREGS),
        .WRAP  (1)
    ) u_wp (
        .clk      (bus_clk),
        .srst     (bus_rst),
        .load     (user_control_regs_16_addr_update),
        .load_val (user_control_regs_16_addr),
        .inc      (wr_fire),
        .ptr      (wp)
    );

    // ---------------- read side ----------------
    logic [AW:0]   rp;
    logic          rp_end;
    logic          settle_reg;
    logic          r_open_reg;
    logic          open_rise;
    logic          snap_take;
    logic          empty;
    logic          rd_fire;
    xb_word_t      rd_data_reg;
    xb_word_t      rd_view [NREGS];

    assign rp_end    = (WRAP == 0) && (rp == (AW+1)'(NREGS));
    assign open_rise = user_r_status_regs_16_open & ~r_open_reg;
    assign snap_take = user_status_regs_16_addr_update | open_rise;
    assign empty     = ~user_r_status_regs_16_open | settle_reg | rp_end;
    // A read request in the seek cycle is dropped; the seek forces empty next cycle anyway
    assign rd_fire   = user_r_status_regs_16_rden & ~empty & ~user_status_regs_16_addr_update;

    xb_seek_ptr #(
        .W     (AW + 1),
        .LIMIT (NREGS),
        .WRAP  (WRAP)
    ) u_rp (
        .clk      (bus_clk),
        .srst     (bus_rst),
        .load     (user_status_regs_16_addr_update),
        .load_val ({1'b0, user_status_regs_16_addr}),
        .inc      (rd_fire),
        .ptr      (rp)
    );

    // ---------------- register banks ----------------
    for (genvar gi = 0; gi < RO_BASE; gi++) begin : g_ctrl
        xb_word_t word_reg;
        logic     strobe_reg;

        always_ff @(posedge bus_clk) begin
            if (bus_rst) begin
                word_reg   <= '0;
                strobe_reg <= 1'b0;
            end else begin
                if (wr_ctrl && (wr_idx == AW'(gi))) begin
                    word_reg <= user_w_control_regs_16_data;
                end
                strobe_reg <= wr_ctrl && (wr_idx == AW'(gi));
            end
        end

        assign ctrl_out[gi*XB_DW +: XB_DW] = word_reg;
        assign ctrl_wr_strobe[gi]          = strobe_reg;
        assign rd_view[gi]                 = word_reg;
    end

    // Status words are frozen at the start of each read sequence so a
    // multi-word read sees one coherent set.
    for (genvar gi = 0; gi < NSTAT; gi++) begin : g_snap
        xb_word_t snap_reg;

        always_ff @(posedge bus_clk) begin
            if (bus_rst) begin
                snap_reg <= '0;
            end else if (snap_take) begin
                snap_reg <= status_in[gi*XB_DW +: XB_DW];
            end
        end

        assign rd_view[RO_BASE + gi] = snap_reg;
    end

    // ---------------- control/state flops ----------------
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            full_reg         <= 1'b1;
            ro_violation_reg <= 1'b0;
            settle_reg       <= 1'b1;
            r_open_reg       <= 1'b0;
            rd_data_reg      <= '0;
        end else begin
            full_reg   <= 1'b0;
            settle_reg <= snap_take;
            r_open_reg <= user_r_status_regs_16_open;
            if (wr_ro) begin
                ro_violation_reg <= 1'b1;
            end
            // rd_view holds pre-write control values, giving read-before-write
            if (rd_fire) begin
                rd_data_reg <= rd_view[rp[AW-1:0]];
            end
        end
    end

    assign user_w_control_regs_16_full = bus_rst | full_reg;
    assign user_r_status_regs_16_data  = rd_data_reg;
    assign user_r_status_regs_16_empty = empty;
    assign user_r_status_regs_16_eof   = rp_end;
    assign ro_violation                = ro_violation_reg;

endmodule

// File: tb/tb_xb_ctrl_regfile.sv
// Self-checking bench for xb_ctrl_regfile (instantiated with WRAP=0):
// directed test-plan steps followed by a random phase, all checked against
// a behavioural register-file model.
module tb_xb_ctrl_regfile;
    import xb_regfile_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         w_open = 1'b0, wren = 1'b0, w_upd = 1'b0;
    logic [15:0]  w_data = '0;
    logic [4:0]   w_addr = '0;
    logic         w_full;
    logic         r_open = 1'b0, rden = 1'b0, r_upd = 1'b0;
    logic [4:0]   r_addr = '0;
    logic [15:0]  r_data;
    logic         r_empty, r_eof;
    logic [255:0] status_in = '0;
    logic [255:0] ctrl_out;
    logic [15:0]  strobe;
    logic         rov;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [15:0] m_ctrl [16];
    logic [15:0] m_snap [16];
    logic [15:0] m_data;
    int          m_wp, m_rp, m_strobe;
    bit          m_rov, m_settle, m_open_prev, m_full;

    always #5 clk = ~clk;

    xb_ctrl_regfile #(.NREGS(32), .RO_BASE(16), .WRAP(0)) dut (
        .bus_clk                          (clk),
        .bus_rst                          (rst),
        .user_w_control_regs_16_open      (w_open),
        .user_w_control_regs_16_wren      (wren),
        .user_w_control_regs_16_data      (w_data),
        .user_w_control_regs_16_full      (w_full),
        .user_control_regs_16_addr        (w_addr),
        .user_control_regs_16_addr_update (w_upd),
        .user_r_status_regs_16_open       (r_open),
        .user_r_status_regs_16_rden       (rden),
        .user_r_status_regs_16_data       (r_data),
        .user_r_status_regs_16_empty      (r_empty),
        .user_r_status_regs_16_eof        (r_eof),
        .user_status_regs_16_addr         (r_addr),
        .user_status_regs_16_addr_update  (r_upd),
        .status_in                        (status_in),
        .ctrl_out                         (ctrl_out),
        .ctrl_wr_strobe                   (strobe),
        .ro_violation                     (rov)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit is_empty;
        int idx;
        bit rise;
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_ctrl[k] = '0;
                m_snap[k] = '0;
            end
            m_data = '0; m_wp = 0; m_rp = 0; m_strobe = -1;
            m_rov = 0; m_settle = 1; m_open_prev = 0; m_full = 1;
        end else begin
            // read uses register contents from before this edge's write
            is_empty = !r_open || m_settle || (m_rp == 32);
            if (r_upd) begin
                m_rp = r_addr;
            end else if (rden && !is_empty) begin
                m_data = (m_rp < 16) ? m_ctrl[m_rp] : m_snap[m_rp - 16];
                m_rp   = m_rp + 1;
            end
            rise = r_open && !m_open_prev;
            if (r_upd || rise) begin
                for (int k = 0; k < 16; k++) m_snap[k] = status_in[k*16 +: 16];
            end
            m_settle    = r_upd || rise;
            m_open_prev = r_open;

            m_strobe = -1;
            if (w_open && wren) begin
                idx = w_upd ? int'(w_addr) : m_wp;
                if (idx < 16) begin
                    m_ctrl[idx] = w_data;
                    m_strobe    = idx;
                end else begin
                    m_rov = 1;
                end
                m_wp = (idx + 1) % 32;
            end else if (w_upd) begin
                m_wp = w_addr;
            end
            m_full = 0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s ctrl[%0d]", tag, k), {16'h0, ctrl_out[k*16 +: 16]}, {16'h0, m_ctrl[k]});
        chk({tag, " strobe"}, {16'h0, strobe}, (m_strobe < 0) ? 32'h0 : (32'h1 << m_strobe));
        chk({tag, " rov"},    {31'h0, rov},     {31'h0, m_rov});
        chk({tag, " full"},   {31'h0, w_full},  {31'h0, (rst || m_full)});
        chk({tag, " rdata"},  {16'h0, r_data},  {16'h0, m_data});
        chk({tag, " empty"},  {31'h0, r_empty}, {31'h0, (!r_open || m_settle || m_rp == 32)});
        chk({tag, " eof"},    {31'h0, r_eof},   {31'h0, (m_rp == 32)});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        $display("step %-12s wp=%0d rp=%0d ctrl_wr=%0d rdata=%h empty=%0b eof=%0b rov=%0b",
                 tag, m_wp, m_rp, m_strobe, r_data, r_empty, r_eof, rov);
    endtask

    initial begin
        // ---- reset: full high during reset and the cycle after ----
        rst = 1'b1;
        step("reset");
        chk("full_in_rst", {31'h0, w_full}, 32'h1);
        chk("empty_rst", {31'h0, r_empty}, 32'h1);
        rst = 1'b0;
        #1;
        chk("full_after_rst", {31'h0, w_full}, 32'h1);
        step("idle");
        chk("full_clear", {31'h0, w_full}, 32'h0);

        // ---- seek write pointer to 3, two back-to-back writes ----
        w_open = 1'b1; w_addr = 5'd3; w_upd = 1'b1;
        step("wseek3");
        w_upd = 1'b0; wren = 1'b1; w_data = 16'h1111;
        step("wr3");
        chk("ctrl3", {16'h0, ctrl_out[3*16 +: 16]}, 32'h1111);
        chk("strobe3", {16'h0, strobe}, 32'h0008);
        w_data = 16'h2222;
        step("wr4");
        chk("ctrl4", {16'h0, ctrl_out[4*16 +: 16]}, 32'h2222);
        chk("strobe4", {16'h0, strobe}, 32'h0010);
        wren = 1'b0;
        step("wr_idle");
        chk("strobe_off", {16'h0, strobe}, 32'h0);

        // ---- write 15 then the read-only index 16 ----
        w_addr = 5'd15; w_upd = 1'b1; wren = 1'b1; w_data = 16'h00F5;
        step("wr15");
        chk("ctrl15", {16'h0, ctrl_out[15*16 +: 16]}, 32'h00F5);
        w_upd = 1'b0; w_data = 16'hBEEF;
        step("wr16_ro");
        chk("rov_set", {31'h0, rov}, 32'h1);
        chk("ro_no_strobe", {16'h0, strobe}, 32'h0);
        wren = 1'b0;
        step("ro_hold");
        chk("rov_sticky", {31'h0, rov}, 32'h1);

        // ---- snapshot coherency ----
        status_in[15:0] = 16'hAAAA;
        r_open = 1'b1;
        step("ropen");
        step("ropen2");
        r_addr = 5'(STAT_FIFO_LVL); r_upd = 1'b1;
        step("rseek16");
        chk("settle_empty", {31'h0, r_empty}, 32'h1);
        r_upd = 1'b0; status_in[15:0] = 16'h5555;
        step("settled");
        chk("empty_clear", {31'h0, r_empty}, 32'h0);
        rden = 1'b1;
        step("rd16");
        chk("snap_word", {16'h0, r_data}, 32'hAAAA);
        rden = 1'b0;

        // ---- end of file at NREGS ----
        r_addr = 5'd30; r_upd = 1'b1;
        step("rseek30");
        r_upd = 1'b0;
        step("settle30");
        rden = 1'b1;
        step("rd30");
        step("rd31");
        chk("eof_set", {31'h0, r_eof}, 32'h1);
        chk("eof_empty", {31'h0, r_empty}, 32'h1);
        step("rd_ignored");
        chk("eof_hold", {31'h0, r_eof}, 32'h1);
        rden = 1'b0; r_addr = 5'd0; r_upd = 1'b1;
        step("rseek0");
        chk("eof_clear", {31'h0, r_eof}, 32'h0);
        r_upd = 1'b0;

        // ---- read-before-write on the same control index ----
        w_addr = 5'(CTRL_THR_SCALE); w_upd = 1'b1; wren = 1'b1; w_data = 16'h0007;
        step("wr2_old");
        w_upd = 1'b0; wren = 1'b0;
        r_addr = 5'(CTRL_THR_SCALE); r_upd = 1'b1;
        step("rseek2");
        r_upd = 1'b0;
        step("settle2");
        w_upd = 1'b1; wren = 1'b1; w_data = 16'h0009; rden = 1'b1;
        step("rw2");
        chk("rbw_old", {16'h0, r_data}, 32'h0007);
        chk("rbw_new", {16'h0, ctrl_out[CTRL_THR_SCALE*16 +: 16]}, 32'h0009);
        w_upd = 1'b0; wren = 1'b0; rden = 1'b0; r_upd = 1'b1;
        step("rseek2b");
        r_upd = 1'b0;
        step("settle2b");
        rden = 1'b1;
        step("rd2_new");
        chk("rd_new", {16'h0, r_data}, 32'h0009);
        rden = 1'b0;

        // ---- random traffic ----
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            w_open = ($urandom_range(0, 19) != 0);
            r_open = ($urandom_range(0, 19) != 0);
            wren   = $urandom_range(0, 1) == 1;
            rden   = $urandom_range(0, 1) == 1;
            w_upd  = ($urandom_range(0, 7) == 0);
            r_upd  = ($urandom_range(0, 9) == 0);
            w_addr = 5'($urandom_range(0, 31));
            r_addr = 5'($urandom_range(0, 31));
            w_data = 16'($urandom);
            for (int k = 0; k < 16; k++) status_in[k*16 +: 16] = 16'($urandom);
            step($sformatf("rnd%0d", i));
        end
        rst = 1'b0;

        // ---- reset in the middle of a burst ----
        w_open = 1'b1; r_open = 1'b1; w_upd = 1'b0; r_upd = 1'b0;
        wren = 1'b1; rden = 1'b1;
        step("burst");
        w_data = 16'h1234; rst = 1'b1;
        step("mid_rst");
        chk("mid_rst_full", {31'h0, w_full}, 32'h1);
        chk("mid_rst_ctrl", ctrl_out[31:0], 32'h0);
        chk("mid_rst_strobe", {16'h0, strobe}, 32'h0);
        chk("mid_rst_rov", {31'h0, rov}, 32'h0);
        chk("mid_rst_rdata", {16'h0, r_data}, 32'h0);
        rst = 1'b0; wren = 1'b0; rden = 1'b0;
        #1;
        chk("mid_rst_full2", {31'h0, w_full}, 32'h1);
        step("post_rst");
        chk("mid_rst_full3", {31'h0, w_full}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
